// File: rtl/sync_fifo_gb_pkg.sv
// Shared helpers for sync_fifo_gearbox: unit/ratio/width functions, flag bundle and parameter checks.
package sync_fifo_gb_pkg;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
  } fifo_flags_t;

  localparam fifo_flags_t FIFO_FLAGS_RESET = '{
    full:         1'b0,
    almost_full:  1'b0,
    empty:        1'b1,
    almost_empty: 1'b1
  };

  function automatic int unit_width(input int din_w, input int dout_w);
    return (din_w < dout_w) ? din_w : dout_w;
  endfunction

  function automatic int wr_units(input int din_w, input int dout_w);
    return din_w / unit_width(din_w, dout_w);
  endfunction

  function automatic int rd_units(input int din_w, input int dout_w);
    return dout_w / unit_width(din_w, dout_w);
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit widths_ok(input int din_w, input int dout_w);
    int lo;
    int hi;
    lo = unit_width(din_w, dout_w);
    hi = (din_w > dout_w) ? din_w : dout_w;
    return (lo > 0) && ((hi % lo) == 0);
  endfunction

  // Depth must hold two of the larger transfers so a full write and a full read can overlap.
  function automatic bit depth_ok(input int din_w, input int dout_w, input int depth);
    int wr_u;
    int rd_u;
    int big;
    wr_u = wr_units(din_w, dout_w);
    rd_u = rd_units(din_w, dout_w);
    big  = (wr_u > rd_u) ? wr_u : rd_u;
    return is_pow2(depth) && (depth >= 2 * big);
  endfunction

endpackage

// File: rtl/sync_fifo_gb_ram.sv
// Unit-granular register array: one WR_U-unit write port and one RD_U-unit unregistered read port.
module sync_fifo_gb_ram
  import sync_fifo_gb_pkg::*;
#(
  parameter int UNIT_W      = 8,
  parameter int WR_U        = 1,
  parameter int RD_U        = 4,
  parameter int DEPTH_UNITS = 16,
  parameter int ADDR_W      = $clog2(DEPTH_UNITS)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [WR_U*UNIT_W-1:0]   wdata,
  input  logic [ADDR_W-1:0]        raddr,
  output logic [RD_U*UNIT_W-1:0]   rdata
);

  logic [UNIT_W-1:0] mem [DEPTH_UNITS];

  // Slice k goes to start+k; the ADDR_W-bit sum wraps at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < WR_U; k++) begin
        mem[waddr + ADDR_W'(k)] <= wdata[k*UNIT_W +: UNIT_W];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < RD_U; k++) begin
      rdata[k*UNIT_W +: UNIT_W] = mem[raddr + ADDR_W'(k)];
    end
  end

endmodule

// File: rtl/sync_fifo_gearbox.sv
// Single-clock FIFO converting between integer-ratio widths, stored in min-width units.
// Define FIFO_GB_ERR_FLAGS_EN to build sticky overflow/underflow flags; otherwise they are tied low.
module sync_fifo_gearbox
  import sync_fifo_gb_pkg::*;
#(
  parameter int DIN_WIDTH   = 8,
  parameter int DOUT_WIDTH  = 32,
  parameter int DEPTH_UNITS = 16,
  parameter int FWFT_EN     = 1,
  parameter int MSB_FIFO    = 1,
  parameter int AF_LEVEL    = DEPTH_UNITS - wr_units(DIN_WIDTH, DOUT_WIDTH),
  parameter int AE_LEVEL    = rd_units(DIN_WIDTH, DOUT_WIDTH)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clr,
  input  logic [DIN_WIDTH-1:0]                  din,
  input  logic                                  wr_en,
  output logic                                  full,
  output logic                                  almost_full,
  output logic [DOUT_WIDTH-1:0]                 dout,
  input  logic                                  rd_en,
  output logic                                  empty,
  output logic                                  almost_empty,
  output logic [level_width(DEPTH_UNITS)-1:0]   level,
  output logic                                  overflow,
  output logic                                  underflow
);

  localparam int U      = unit_width(DIN_WIDTH, DOUT_WIDTH);
  localparam int WR_U   = wr_units(DIN_WIDTH, DOUT_WIDTH);
  localparam int RD_U   = rd_units(DIN_WIDTH, DOUT_WIDTH);
  localparam int PTR_W  = ptr_width(DEPTH_UNITS);
  localparam int ADDR_W = PTR_W - 1;
  localparam int LVL_W  = level_width(DEPTH_UNITS);
  localparam int LVL_X  = LVL_W + 1;

  localparam logic [LVL_X-1:0] WR_INC  = LVL_X'(WR_U);
  localparam logic [LVL_X-1:0] RD_DEC  = LVL_X'(RD_U);
  localparam logic [LVL_X-1:0] FULL_AT = LVL_X'(DEPTH_UNITS - WR_U + 1);
  localparam logic [LVL_X-1:0] AF_AT   = LVL_X'(AF_LEVEL);
  localparam logic [LVL_X-1:0] AE_AT   = LVL_X'(AE_LEVEL);

  if (!widths_ok(DIN_WIDTH, DOUT_WIDTH)) begin : g_bad_widths
    $error("sync_fifo_gearbox: larger width must be a multiple of the smaller width");
  end
  if (!depth_ok(DIN_WIDTH, DOUT_WIDTH, DEPTH_UNITS)) begin : g_bad_depth
    $error("sync_fifo_gearbox: DEPTH_UNITS must be a power of two and >= 2*max(WR_U,RD_U)");
  end

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  fifo_flags_t           flags_q, flags_d;
  logic [LVL_X-1:0]      level_nx;
  logic                  wr_acc, rd_acc;
  logic [DIN_WIDTH-1:0]  wr_units_data;
  logic [DOUT_WIDTH-1:0] rd_units_data;
  logic [DOUT_WIDTH-1:0] head_word;

  assign wr_acc = wr_en & ~flags_q.full  & ~clr;
  assign rd_acc = rd_en & ~flags_q.empty & ~clr;

  // Level math is one bit wider than level; flags come from the next level so they are registered.
  always_comb begin
    level_nx = {1'b0, level_q};
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      level_nx = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) begin
        level_nx = level_nx + WR_INC;
        wr_ptr_d = wr_ptr_q + PTR_W'(WR_U);
      end
      if (rd_acc) begin
        level_nx = level_nx - RD_DEC;
        rd_ptr_d = rd_ptr_q + PTR_W'(RD_U);
      end
    end
    level_d              = level_nx[LVL_W-1:0];
    flags_d.full         = (level_nx >= FULL_AT);
    flags_d.almost_full  = (level_nx >= AF_AT);
    flags_d.empty        = (level_nx < RD_DEC);
    flags_d.almost_empty = (level_nx <= AE_AT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      flags_q  <= FIFO_FLAGS_RESET;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      flags_q  <= flags_d;
    end
  end

  // Unit 0 is the first-in unit; MSB_FIFO selects which end of the bus it occupies.
  always_comb begin
    wr_units_data = '0;
    for (int k = 0; k < WR_U; k++) begin
      if (MSB_FIFO != 0) wr_units_data[k*U +: U] = din[DIN_WIDTH-1-k*U -: U];
      else               wr_units_data[k*U +: U] = din[k*U +: U];
    end
  end

  always_comb begin
    head_word = '0;
    for (int k = 0; k < RD_U; k++) begin
      if (MSB_FIFO != 0) head_word[DOUT_WIDTH-1-k*U -: U] = rd_units_data[k*U +: U];
      else               head_word[k*U +: U]              = rd_units_data[k*U +: U];
    end
  end

  sync_fifo_gb_ram #(
    .UNIT_W      (U),
    .WR_U        (WR_U),
    .RD_U        (RD_U),
    .DEPTH_UNITS (DEPTH_UNITS),
    .ADDR_W      (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (wr_units_data),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (rd_units_data)
  );

  if (FWFT_EN != 0) begin : g_fwft
    assign dout = flags_q.empty ? '0 : head_word;
  end else begin : g_std
    logic [DOUT_WIDTH-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (rd_acc) dout_d = head_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout_q <= '0;
      else        dout_q <= dout_d;
    end

    assign dout = dout_q;
  end

`ifdef FIFO_GB_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky until rst_n; clr intentionally leaves them set.
  always_comb begin
    overflow_d  = overflow_q  | (wr_en & flags_q.full);
    underflow_d = underflow_q | (rd_en & flags_q.empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign full         = flags_q.full;
  assign almost_full  = flags_q.almost_full;
  assign empty        = flags_q.empty;
  assign almost_empty = flags_q.almost_empty;
  assign level        = level_q;

endmodule
